// File: rtl/haze_pkg.sv
// Shared types, widths and default parameters for the atmospheric-light estimation path.
package haze_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_CALC,
    ST_COMMIT
  } state_e;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned DIM_W     = 11;
  localparam int unsigned PIX_CNT_W = 21;
  localparam int unsigned FCNT_W    = 16;

  localparam logic [DIM_W-1:0] IMG_HDISP_DEF = 11'd1024;
  localparam logic [DIM_W-1:0] IMG_VDISP_DEF = 11'd768;
  localparam logic [PIX_W-1:0] A_INIT_DEF    = 8'd220;
  localparam logic [PIX_W-1:0] A_MIN_DEF     = 8'd128;
  localparam int unsigned      IIR_SHIFT_DEF = 2;

  // Expected number of qualified pixels in one complete frame.
  function automatic logic [PIX_CNT_W-1:0] frame_pixels(input logic [DIM_W-1:0] hdisp,
                                                        input logic [DIM_W-1:0] vdisp);
    return PIX_CNT_W'(hdisp) * PIX_CNT_W'(vdisp);
  endfunction

endpackage

// File: rtl/rgb_max3.sv
// Combinational maximum of three 8-bit colour channels.
module rgb_max3
  import haze_pkg::*;
(
  input  logic [PIX_W-1:0] red,
  input  logic [PIX_W-1:0] green,
  input  logic [PIX_W-1:0] blue,
  output logic [PIX_W-1:0] max_c
);

  logic [PIX_W-1:0] rg_c;

  always_comb begin
    rg_c  = (red >= green) ? red : green;
    max_c = (rg_c >= blue) ? rg_c : blue;
  end

endmodule

// File: rtl/haze_atmos_light_ctrl.sv
// Per-frame atmospheric light estimator: tracks the brightest dark-channel pixel,
// validates the frame size, IIR-smooths the candidate and commits it as A.
module haze_atmos_light_ctrl
  import haze_pkg::*;
#(
  parameter logic [DIM_W-1:0] IMG_HDISP = IMG_HDISP_DEF,
  parameter logic [DIM_W-1:0] IMG_VDISP = IMG_VDISP_DEF,
  parameter logic [PIX_W-1:0] A_INIT    = A_INIT_DEF,
  parameter logic [PIX_W-1:0] A_MIN     = A_MIN_DEF,
  parameter int unsigned      IIR_SHIFT = IIR_SHIFT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              dark_vsync,
  input  logic              dark_href,
  input  logic              dark_clken,
  input  logic [PIX_W-1:0]  dark_value,
  input  logic [PIX_W-1:0]  dark_red,
  input  logic [PIX_W-1:0]  dark_green,
  input  logic [PIX_W-1:0]  dark_blue,
  output logic [PIX_W-1:0]  atmos_light,
  output logic              atmos_valid,
  output logic              update_pulse,
  output logic              frame_err,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam logic [PIX_CNT_W-1:0] FRAME_PIX = frame_pixels(IMG_HDISP, IMG_VDISP);

  // Input capture stage; vsync history resets high so a frame in flight at reset release is ignored.
  logic             enable_q;
  logic             vsync_q;
  logic             vsync_dly_q;
  logic             href_q;
  logic             clken_q;
  logic [PIX_W-1:0] dark_q;
  logic [PIX_W-1:0] red_q;
  logic [PIX_W-1:0] green_q;
  logic [PIX_W-1:0] blue_q;

  state_e                state_q, state_d;
  logic [PIX_W-1:0]      max_dark_q, max_dark_d;
  logic [PIX_W-1:0]      cand_q, cand_d;
  logic [PIX_W-1:0]      a_next_q, a_next_d;
  logic [PIX_CNT_W-1:0]  pix_cnt_q, pix_cnt_d;
  logic                  pending_q, pending_d;
  logic [PIX_W-1:0]      atmos_light_q, atmos_light_d;
  logic                  atmos_valid_q, atmos_valid_d;
  logic                  update_pulse_q, update_pulse_d;
  logic                  frame_err_q, frame_err_d;
  logic [FCNT_W-1:0]     frame_cnt_q, frame_cnt_d;

  logic                  rise_c;
  logic                  fall_c;
  logic                  pix_c;
  logic [PIX_W-1:0]      rgb_max_c;
  logic [PIX_W-1:0]      a_cur_c;
  logic signed [PIX_W:0] diff_c;
  logic signed [PIX_W:0] step_c;
  logic [PIX_W-1:0]      a_iir_c;

  rgb_max3 u_rgb_max3 (
    .red   (red_q),
    .green (green_q),
    .blue  (blue_q),
    .max_c (rgb_max_c)
  );

  // Candidate clamp and IIR step; the true sum is always in 0..255, so modulo-256 add is exact.
  always_comb begin
    a_cur_c = (cand_q < A_MIN) ? A_MIN : cand_q;
    diff_c  = $signed({1'b0, a_cur_c}) - $signed({1'b0, atmos_light_q});
    step_c  = diff_c >>> IIR_SHIFT;
    a_iir_c = PIX_W'(atmos_light_q + PIX_W'(step_c));
  end

  always_comb begin
    rise_c = vsync_q & ~vsync_dly_q;
    fall_c = ~vsync_q & vsync_dly_q;
    pix_c  = vsync_q & href_q & clken_q;

    state_d        = state_q;
    max_dark_d     = max_dark_q;
    cand_d         = cand_q;
    a_next_d       = a_next_q;
    pix_cnt_d      = pix_cnt_q;
    pending_d      = pending_q;
    atmos_light_d  = atmos_light_q;
    atmos_valid_d  = atmos_valid_q;
    update_pulse_d = 1'b0;
    frame_err_d    = frame_err_q;
    frame_cnt_d    = frame_cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if ((rise_c & enable_q) | pending_q) begin
          max_dark_d = '0;
          cand_d     = '0;
          pix_cnt_d  = '0;
          pending_d  = 1'b0;
          state_d    = ST_ACCUM;
        end
      end

      ST_ACCUM: begin
        if (pix_c) begin
          if (pix_cnt_q != {PIX_CNT_W{1'b1}}) begin
            pix_cnt_d = pix_cnt_q + PIX_CNT_W'(1);
          end
          // Strict compare keeps the earliest pixel on ties.
          if (dark_q > max_dark_q) begin
            max_dark_d = dark_q;
            cand_d     = rgb_max_c;
          end
        end
        if (fall_c) begin
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (rise_c & enable_q) begin
          pending_d = 1'b1;
        end
        if (pix_cnt_q != FRAME_PIX) begin
          frame_err_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          a_next_d = atmos_valid_q ? a_iir_c : a_cur_c;
          state_d  = ST_COMMIT;
        end
      end

      ST_COMMIT: begin
        if (rise_c & enable_q) begin
          pending_d = 1'b1;
        end
        atmos_light_d  = a_next_q;
        atmos_valid_d  = 1'b1;
        update_pulse_d = 1'b1;
        frame_cnt_d    = frame_cnt_q + FCNT_W'(1);
        frame_err_d    = 1'b0;
        state_d        = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enable_q       <= 1'b0;
      vsync_q        <= 1'b1;
      vsync_dly_q    <= 1'b1;
      href_q         <= 1'b0;
      clken_q        <= 1'b0;
      dark_q         <= '0;
      red_q          <= '0;
      green_q        <= '0;
      blue_q         <= '0;
      state_q        <= ST_IDLE;
      max_dark_q     <= '0;
      cand_q         <= '0;
      a_next_q       <= '0;
      pix_cnt_q      <= '0;
      pending_q      <= 1'b0;
      atmos_light_q  <= A_INIT;
      atmos_valid_q  <= 1'b0;
      update_pulse_q <= 1'b0;
      frame_err_q    <= 1'b0;
      frame_cnt_q    <= '0;
    end else begin
      enable_q       <= enable;
      vsync_q        <= dark_vsync;
      vsync_dly_q    <= vsync_q;
      href_q         <= dark_href;
      clken_q        <= dark_clken;
      dark_q         <= dark_value;
      red_q          <= dark_red;
      green_q        <= dark_green;
      blue_q         <= dark_blue;
      state_q        <= state_d;
      max_dark_q     <= max_dark_d;
      cand_q         <= cand_d;
      a_next_q       <= a_next_d;
      pix_cnt_q      <= pix_cnt_d;
      pending_q      <= pending_d;
      atmos_light_q  <= atmos_light_d;
      atmos_valid_q  <= atmos_valid_d;
      update_pulse_q <= update_pulse_d;
      frame_err_q    <= frame_err_d;
      frame_cnt_q    <= frame_cnt_d;
    end
  end

  assign atmos_light  = atmos_light_q;
  assign atmos_valid  = atmos_valid_q;
  assign update_pulse = update_pulse_q;
  assign frame_err    = frame_err_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_haze_atmos_light_ctrl.sv
// Bench for haze_atmos_light_ctrl on a 4x2 frame: randomized frames against a frame-level model.
module tb_haze_atmos_light_ctrl;

  localparam logic [10:0] H    = 11'd4;
  localparam logic [10:0] V    = 11'd2;
  localparam int          NPIX = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dark_vsync;
  logic        dark_href;
  logic        dark_clken;
  logic [7:0]  dark_value;
  logic [7:0]  dark_red;
  logic [7:0]  dark_green;
  logic [7:0]  dark_blue;
  logic [7:0]  atmos_light;
  logic        atmos_valid;
  logic        update_pulse;
  logic        frame_err;
  logic [15:0] frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Frame-level reference state.
  int m_a;
  int m_valid;
  int m_cnt;
  int m_err;

  int px_d[NPIX];
  int px_r[NPIX];
  int px_g[NPIX];
  int px_b[NPIX];
  bit chained = 1'b0;

  haze_atmos_light_ctrl #(
    .IMG_HDISP (H),
    .IMG_VDISP (V),
    .A_INIT    (8'd220),
    .A_MIN     (8'd128),
    .IIR_SHIFT (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .dark_vsync   (dark_vsync),
    .dark_href    (dark_href),
    .dark_clken   (dark_clken),
    .dark_value   (dark_value),
    .dark_red     (dark_red),
    .dark_green   (dark_green),
    .dark_blue    (dark_blue),
    .atmos_light  (atmos_light),
    .atmos_valid  (atmos_valid),
    .update_pulse (update_pulse),
    .frame_err    (frame_err),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 220; m_valid = 0; m_cnt = 0; m_err = 0;
  endtask

  // Apply the frame rules to the model: validate count, pick brightest-dark pixel, clamp, smooth.
  task automatic model_frame(input int npix, input bit en);
    int best, cand, acur, diff, step, mx;
    if (en) begin
      if (npix != NPIX) begin
        m_err = 1;
      end else begin
        best = 0; cand = 0;
        for (int p = 0; p < NPIX; p++) begin
          mx = px_r[p];
          if (px_g[p] > mx) mx = px_g[p];
          if (px_b[p] > mx) mx = px_b[p];
          if (px_d[p] > best) begin best = px_d[p]; cand = mx; end
        end
        acur = (cand < 128) ? 128 : cand;
        if (m_valid == 0) begin
          m_a = acur;
        end else begin
          diff = acur - m_a;
          step = (diff >= 0) ? diff / 4 : -((-diff + 3) / 4);
          m_a  = m_a + step;
        end
        m_valid = 1;
        m_cnt   = (m_cnt + 1) % 65536;
        m_err   = 0;
      end
    end
  endtask

  task automatic fill_random(input int dmax, input int cmax);
    for (int p = 0; p < NPIX; p++) begin
      px_d[p] = $urandom_range(dmax, 0);
      px_r[p] = $urandom_range(cmax, 0);
      px_g[p] = $urandom_range(cmax, 0);
      px_b[p] = $urandom_range(cmax, 0);
    end
  endtask

  // Drive one frame (npix qualified pixels), then check the commit window after vsync falls.
  task automatic run_frame(input string tag, input int npix, input bit en,
                           input bit drop_en, input bit chain_next);
    int slot;
    bit exp_pulse;
    if (!chained) begin
      @(negedge clk);
      dark_vsync = 1'b1;
      enable     = en;
      repeat (3) @(negedge clk);
    end
    slot = 0;
    for (int l = 0; l < int'(V); l++) begin
      for (int x = 0; x < int'(H); x++) begin
        repeat ($urandom_range(1, 0)) begin
          dark_href = 1'b1; dark_clken = 1'b0; dark_value = 8'd255;
          @(negedge clk);
        end
        dark_href  = 1'b1;
        dark_clken = (slot < npix);
        dark_value = 8'(px_d[slot]);
        dark_red   = 8'(px_r[slot]);
        dark_green = 8'(px_g[slot]);
        dark_blue  = 8'(px_b[slot]);
        @(negedge clk);
        slot++;
      end
      // Strobe outside the line window with a bright pixel that must not count.
      dark_href = 1'b0; dark_clken = 1'b1; dark_value = 8'd255;
      dark_red = 8'd255; dark_green = 8'd255; dark_blue = 8'd255;
      @(negedge clk);
      dark_clken = 1'b0;
      @(negedge clk);
      if (drop_en && l == 0) enable = 1'b0;
    end
    dark_vsync = 1'b0; dark_href = 1'b0; dark_clken = 1'b0;
    exp_pulse = en && (npix == NPIX);
    model_frame(npix, en);
    @(negedge clk);
    @(negedge clk);
    if (chain_next) begin dark_vsync = 1'b1; enable = 1'b1; end
    @(negedge clk);
    check({tag, "_pulse_early"}, update_pulse, 0);
    @(negedge clk);
    check({tag, "_pulse"}, update_pulse, exp_pulse);
    check({tag, "_a"},     atmos_light,  m_a);
    check({tag, "_valid"}, atmos_valid,  m_valid);
    check({tag, "_cnt"},   frame_cnt,    m_cnt);
    check({tag, "_err"},   frame_err,    m_err);
    @(negedge clk);
    check({tag, "_pulse_drop"}, update_pulse, 0);
    chained = chain_next;
  endtask

  initial begin
    int np;
    bit en;
    rst = 1'b1; enable = 1'b0; dark_vsync = 1'b0; dark_href = 1'b0; dark_clken = 1'b0;
    dark_value = '0; dark_red = '0; dark_green = '0; dark_blue = '0;
    model_reset();
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_a", atmos_light, 220);
    check("rst_valid", atmos_valid, 0);
    check("rst_pulse", update_pulse, 0);
    check("rst_err", frame_err, 0);
    check("rst_cnt", frame_cnt, 0);

    // Peak dark 200 at pixel 3 with RGB (230,240,250).
    fill_random(199, 255);
    px_d[3] = 200; px_r[3] = 230; px_g[3] = 240; px_b[3] = 250;
    run_frame("t1", NPIX, 1'b1, 1'b0, 1'b0);
    check("t1_a_const", atmos_light, 250);
    check("t1_cnt_const", frame_cnt, 1);

    // Dim frame clamps to 128 and smooths toward it.
    fill_random(255, 100);
    run_frame("t2", NPIX, 1'b1, 1'b0, 1'b0);
    check("t2_a_const", atmos_light, 219);

    // Short frame flags an error, next good frame clears it.
    fill_random(255, 255);
    run_frame("t3_short", 7, 1'b1, 1'b0, 1'b0);
    check("t3_err_const", frame_err, 1);
    fill_random(255, 255);
    run_frame("t3_good", NPIX, 1'b1, 1'b0, 1'b0);

    // Disabled at rise is skipped; dropping enable mid-frame still commits.
    fill_random(255, 255);
    run_frame("t6_off", NPIX, 1'b0, 1'b0, 1'b0);
    fill_random(255, 255);
    run_frame("t6_drop", NPIX, 1'b1, 1'b1, 1'b0);

    // Back-to-back frames with a two-cycle blanking gap.
    fill_random(255, 255);
    run_frame("b2b_a", NPIX, 1'b1, 1'b0, 1'b1);
    fill_random(255, 255);
    run_frame("b2b_b", NPIX, 1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 12; k++) begin
      np = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 5)) : NPIX;
      en = ($urandom_range(4, 0) != 0);
      fill_random(255, 255);
      run_frame("rnd", np, en, 1'b0, 1'b0);
    end

    // Reset released mid-frame: that frame must not commit.
    @(negedge clk);
    rst = 1'b1; dark_vsync = 1'b1; enable = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 12; c++) begin
      dark_href = 1'b1; dark_clken = 1'b1; dark_value = 8'd250;
      dark_red = 8'd250; dark_green = 8'd10; dark_blue = 8'd10;
      @(negedge clk);
      if (c == 5) dark_vsync = 1'b0;
      if (c >= 5) begin dark_href = 1'b0; dark_clken = 1'b0; end
      check("t5_no_pulse", update_pulse, 0);
    end
    check("t5_cnt", frame_cnt, 0);
    check("t5_valid", atmos_valid, 0);
    check("t5_a", atmos_light, 220);

    // First frame after reset with a tie on dark=200: earliest pixel's RGB wins.
    fill_random(199, 255);
    px_d[1] = 200; px_r[1] = 210; px_g[1] = 50;  px_b[1] = 20;
    px_d[5] = 200; px_r[5] = 240; px_g[5] = 10;  px_b[5] = 10;
    run_frame("t4", NPIX, 1'b1, 1'b0, 1'b0);
    check("t4_a_const", atmos_light, 210);
    check("t4_cnt_const", frame_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
